// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with enable, clamped parallel load, wrap or saturate
// boundaries, terminal-count flag and wrap pulse. Optional WrapCount output: UPDOWN_CNT_WRAPCOUNT_EN.
module updown_counter_mod #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned MOD_MAX     = 15,
  parameter bit          SATURATE    = 1'b0,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             En,
  input  logic             UpOrDown,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  output logic [WIDTH-1:0] Count,
  output logic             TermCount,
  output logic             WrapPulse
`ifdef UPDOWN_CNT_WRAPCOUNT_EN
  ,
  output logic [7:0]       WrapCount
`endif
);

  localparam logic [WIDTH-1:0] mod_max   = WIDTH'(MOD_MAX);
  localparam logic [WIDTH-1:0] reset_val = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] one       = WIDTH'(1);

  logic [WIDTH-1:0] next_count;
  logic             at_top;
  logic             at_bottom;

  // Exact compares so a non-power-of-two modulus wraps at MOD_MAX, not at the carry-out
  assign at_top    = (Count == mod_max);
  assign at_bottom = (Count == '0);

  assign TermCount = En & ~Load & ((UpOrDown & at_top) | (~UpOrDown & at_bottom));

  always_comb begin
    next_count = Count;
    if (Load) begin
      next_count = (LoadValue > mod_max) ? mod_max : LoadValue;
    end else if (En) begin
      if (UpOrDown) begin
        if (at_top) begin
          next_count = SATURATE ? mod_max : '0;
        end else begin
          next_count = Count + one;
        end
      end else begin
        if (at_bottom) begin
          next_count = SATURATE ? '0 : mod_max;
        end else begin
          next_count = Count - one;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      Count     <= reset_val;
      WrapPulse <= 1'b0;
    end else begin
      Count     <= next_count;
      WrapPulse <= TermCount;
    end
  end

`ifdef UPDOWN_CNT_WRAPCOUNT_EN
  // Counts the edges that raise WrapPulse, i.e. cycles with TermCount high
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      WrapCount <= 8'd0;
    end else if (Load) begin
      WrapCount <= 8'd0;
    end else if (TermCount && (WrapCount != 8'hFF)) begin
      WrapCount <= WrapCount + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed self-checking bench for updown_counter_mod: a wrap instance (MOD_MAX=9),
// a saturating instance (MOD_MAX=15) and a MOD_MAX=3 instance for the optional WrapCount.
module tb_updown_counter_mod;

  logic       Clk = 1'b0;
  logic       reset;
  logic       En;
  logic       UpOrDown;
  logic       Load;
  logic [3:0] LoadValue;

  logic [3:0] countA, countB, countC;
  logic       tcA, tcB, tcC;
  logic       wpA, wpB, wpC;
`ifdef UPDOWN_CNT_WRAPCOUNT_EN
  logic [7:0] wrapCountC;
`endif

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  updown_counter_mod #(.WIDTH(4), .MOD_MAX(9), .SATURATE(1'b0), .RESET_VALUE(0)) dutA (
    .Clk(Clk), .reset(reset), .En(En), .UpOrDown(UpOrDown), .Load(Load),
    .LoadValue(LoadValue), .Count(countA), .TermCount(tcA), .WrapPulse(wpA)
  );

  updown_counter_mod #(.WIDTH(4), .MOD_MAX(15), .SATURATE(1'b1), .RESET_VALUE(0)) dutB (
    .Clk(Clk), .reset(reset), .En(En), .UpOrDown(UpOrDown), .Load(Load),
    .LoadValue(LoadValue), .Count(countB), .TermCount(tcB), .WrapPulse(wpB)
  );

  updown_counter_mod #(.WIDTH(4), .MOD_MAX(3), .SATURATE(1'b0), .RESET_VALUE(0)) dutC (
    .Clk(Clk), .reset(reset), .En(En), .UpOrDown(UpOrDown), .Load(Load),
    .LoadValue(LoadValue), .Count(countC), .TermCount(tcC), .WrapPulse(wpC)
`ifdef UPDOWN_CNT_WRAPCOUNT_EN
    , .WrapCount(wrapCountC)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drives inputs on the falling edge; TermCount is then stable until the next rising edge
  task automatic applyStimulus(input logic ld, input logic [3:0] val, input logic en, input logic up);
    @(negedge Clk);
    Load      = ld;
    LoadValue = val;
    En        = en;
    UpOrDown  = up;
    #1;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  int downBefore [3] = '{1, 0, 9};
  int downAfter  [3] = '{0, 9, 8};

  initial begin
    reset = 1'b0; En = 1'b0; UpOrDown = 1'b1; Load = 1'b0; LoadValue = 4'd0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    reset = 1'b1;
    #1;
    checkOutput("reset_count", countA, 0);
    checkOutput("reset_wp", wpA, 0);

    // Count up to 9, then assert reset mid-cycle
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b1);
      tick();
    end
    checkOutput("pre_reset_count", countA, 9);
    reset = 1'b0;
    #1;
    checkOutput("async_reset_count", countA, 0);
    checkOutput("async_reset_wp", wpA, 0);
    tick();
    checkOutput("held_reset_count", countA, 0);
    @(negedge Clk);
    reset = 1'b1;
    tick();
    checkOutput("first_after_release", countA, 1);

    // Up wrap over 12 cycles from 0
    applyStimulus(1'b1, 4'd0, 1'b1, 1'b1);
    tick();
    checkOutput("load_zero", countA, 0);
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b1);
      checkOutput("up_tc", tcA, ((k - 1) % 10) == 9);
      tick();
      checkOutput("up_count", countA, k % 10);
      checkOutput("up_wp", wpA, (k % 10) == 0);
    end

    // Down wrap from 1
    applyStimulus(1'b1, 4'd1, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
      checkOutput("down_before", countA, downBefore[k]);
      checkOutput("down_tc", tcA, downBefore[k] == 0);
      tick();
      checkOutput("down_count", countA, downAfter[k]);
      checkOutput("down_wp", wpA, downAfter[k] == 9);
    end

    // Saturate up from 14 and down from 1
    applyStimulus(1'b1, 4'd14, 1'b0, 1'b1);
    tick();
    checkOutput("load14_clamp_a", countA, 9);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b1);
      tick();
      checkOutput("sat_up_count", countB, 15);
      checkOutput("sat_up_wp", wpB, k > 1);
    end
    applyStimulus(1'b1, 4'd1, 1'b0, 1'b0);
    tick();
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
      checkOutput("sat_down_tc", tcB, k > 1);
      tick();
      checkOutput("sat_down_count", countB, 0);
      checkOutput("sat_down_wp", wpB, k > 1);
    end

    // Load beats enable, clamps, and clears a pending pulse
    applyStimulus(1'b1, 4'd12, 1'b1, 1'b0);
    checkOutput("load_tc", tcB, 0);
    tick();
    checkOutput("clamp_count", countA, 9);
    checkOutput("clamp_wp_a", wpA, 0);
    checkOutput("load_b_count", countB, 12);
    checkOutput("load_b_wp", wpB, 0);
    applyStimulus(1'b1, 4'd3, 1'b1, 1'b1);
    tick();
    checkOutput("load3_count", countA, 3);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 4'd7, 1'b0, 1'b1);
      checkOutput("hold_tc", tcA, 0);
      tick();
      checkOutput("hold_count", countA, 3);
      checkOutput("hold_wp", wpA, 0);
    end

`ifdef UPDOWN_CNT_WRAPCOUNT_EN
    applyStimulus(1'b1, 4'd0, 1'b0, 1'b1);
    tick();
    checkOutput("wc_cleared", wrapCountC, 0);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b1);
      tick();
    end
    checkOutput("wc_count_c", countC, 0);
    checkOutput("wc_after20", wrapCountC, 5);
    applyStimulus(1'b1, 4'd2, 1'b0, 1'b1);
    tick();
    checkOutput("wc_load_clear", wrapCountC, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
